pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 81 ++++++++
 tb/tb_pc_redirect_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencing with branch redirect, flush, halt/resume; redirect counter built only when REDIRECT_CNT_EN is defined
module pc_redirect_ctrl #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             pc_sel,
  input  logic [31:0]      branch_pc,
  input  logic             stall,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             misalign_err,
  output logic [15:0]      redirect_cnt
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] pc_nx, pc_seq;
  logic take, halt_take, jump;
  assign take      = ex_valid & pc_sel & (state == RUN);
  assign halt_take = take & (&branch_pc);
  assign jump      = take & ~halt_take;
  assign pc_seq    = stall ? pc : pc + WIDTH'(4);
  // next state and next pc; a redirect outranks stall, HALT ignores everything but resume
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      RUN: begin
        if (halt_take) state_nx = HALT;
        else if (jump) begin
          pc_nx    = {branch_pc[WIDTH-1:2], 2'b00};
          state_nx = FLUSH;
        end else pc_nx = pc_seq;
      end
      FLUSH: begin
        pc_nx    = pc_seq;
        state_nx = RUN;
      end
      HALT: begin
        if (resume) begin
          pc_nx    = '0;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end
  // flushes follow the take combinationally but are forced low while reset is held
  always_comb begin
    flush_if_id = take & rst_n;
    flush_id_ex = take & rst_n;
    halted      = (state == HALT);
  end
  // state, pc and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (jump && |branch_pc[1:0]) misalign_err <= 1'b1;
    end
  end
`ifdef REDIRECT_CNT_EN
  logic [15:0] cnt;
  // saturating count of non-halt redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (jump && ~&cnt) cnt <= cnt + 16'd1;
  end
  assign redirect_cnt = cnt;
`else
  assign redirect_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed bench with a behavioural fetch model checked every cycle
module tb_pc_redirect_ctrl;
  localparam int WIDTH = 9;
  localparam int MOD = 1 << WIDTH;
`ifdef REDIRECT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  logic clk = 0;
  logic rst_n = 1;
  logic ex_valid = 0, pc_sel = 0, stall = 0, resume = 0;
  logic [31:0] branch_pc = 0;
  logic [WIDTH-1:0] pc;
  logic flush_if_id, flush_id_ex, halted, misalign_err;
  logic [15:0] redirect_cnt;
  int checks = 0, failures = 0;
  bit cmp_on = 0;
  pc_redirect_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_sel(pc_sel),
    .branch_pc(branch_pc), .stall(stall), .resume(resume), .pc(pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .halted(halted),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );
  always #5 clk = ~clk;
  // model: mode 0 = running, 1 = one cycle after redirect, 2 = halted
  int m_pc, m_mode, m_cnt;
  bit m_mis;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_mode <= 0; m_cnt <= 0; m_mis <= 0;
    end else if (m_mode == 0 && ex_valid && pc_sel) begin
      if (branch_pc == 32'hFFFFFFFF) m_mode <= 2;
      else begin
        m_pc <= int'(branch_pc % MOD) / 4 * 4;
        m_mode <= 1;
        if (branch_pc % 4 != 0) m_mis <= 1;
        if (CNT_ON == 1 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
    end else if (m_mode == 2) begin
      if (resume) begin m_pc <= 0; m_mode <= 0; end
    end else begin
      if (!stall) m_pc <= (m_pc + 4) % MOD;
      m_mode <= 0;
    end
  end
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_on) begin
    chk("m_pc", 32'(pc), m_pc);
    chk("m_flush_if_id", 32'(flush_if_id), 32'(rst_n && m_mode == 0 && ex_valid && pc_sel));
    chk("m_flush_id_ex", 32'(flush_id_ex), 32'(rst_n && m_mode == 0 && ex_valid && pc_sel));
    chk("m_halted", 32'(halted), 32'(m_mode == 2));
    chk("m_misalign", 32'(misalign_err), 32'(m_mis));
    chk("m_cnt", 32'(redirect_cnt), m_cnt);
  end
  task automatic drive(logic ev, logic ps, logic [31:0] bp, logic st, logic rs);
    @(posedge clk); #1;
    ex_valid = ev; pc_sel = ps; branch_pc = bp; stall = st; resume = rs;
    #1;
  endtask
  initial begin
    #1 rst_n = 0; ex_valid = 1; pc_sel = 1;
    #1 cmp_on = 1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flush", 32'({flush_if_id, flush_id_ex}), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", 32'(redirect_cnt), 0);
    drive(1, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1; ex_valid = 0; pc_sel = 0;
    #1;
    for (int k = 1; k <= 132; k++) begin
      drive(0, 0, 0, 0, 0);
      if (k == 1) chk("seq_first", 32'(pc), 4);
      if (k == 127) chk("seq_508", 32'(pc), 508);
      if (k == 128) chk("seq_wrap", 32'(pc), 0);
    end
    chk("seq_at_10", 32'(pc), 32'h10);
    drive(1, 1, 32'h40, 0, 0);
    chk("br_flush_if_id", 32'(flush_if_id), 1);
    chk("br_flush_id_ex", 32'(flush_id_ex), 1);
    drive(1, 1, 32'h40, 0, 0);
    chk("br_target", 32'(pc), 32'h40);
    chk("br_flush_ignored", 32'(flush_if_id), 0);
    drive(0, 0, 0, 0, 0);
    chk("br_after", 32'(pc), 32'h44);
    chk("br_cnt", 32'(redirect_cnt), CNT_ON * 1);
    drive(1, 1, 32'h80, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("rs_target", 32'(pc), 32'h80);
    drive(0, 0, 0, 0, 0);
    chk("rs_flush_stall", 32'(pc), 32'h80);
    drive(0, 0, 0, 0, 0);
    chk("rs_after", 32'(pc), 32'h84);
    drive(1, 1, 32'h1C, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("h_pre", 32'(pc), 32'h1C);
    drive(1, 1, 32'hFFFFFFFF, 0, 0);
    chk("h_pc20", 32'(pc), 32'h20);
    chk("h_flush", 32'(flush_id_ex), 1);
    drive(1, 1, 32'h40, 1, 0);
    chk("h_hold", 32'(pc), 32'h20);
    chk("h_halted", 32'(halted), 1);
    chk("h_no_flush", 32'(flush_if_id), 0);
    drive(1, 1, 32'h40, 0, 0);
    chk("h_ignore_sel", 32'(pc), 32'h20);
    drive(0, 0, 0, 0, 1);
    chk("h_still", 32'(halted), 1);
    drive(0, 0, 0, 0, 0);
    chk("h_resume_pc", 32'(pc), 0);
    chk("h_resume_halted", 32'(halted), 0);
    chk("h_cnt", 32'(redirect_cnt), CNT_ON * 3);
    drive(0, 0, 0, 0, 1);
    chk("res_run_pc", 32'(pc), 4);
    drive(0, 0, 0, 0, 0);
    chk("res_noeffect", 32'(pc), 8);
    drive(1, 1, 32'h46, 0, 0);
    chk("mis_pre", 32'(misalign_err), 0);
    drive(0, 0, 0, 0, 0);
    chk("mis_pc", 32'(pc), 32'h44);
    chk("mis_set", 32'(misalign_err), 1);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0);
    chk("mis_sticky", 32'(misalign_err), 1);
    chk("mis_pc_later", 32'(pc), 32'h6C);
    drive(1, 1, 32'h1204, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("trunc_pc", 32'(pc), 32'h004);
    chk("trunc_cnt", 32'(redirect_cnt), CNT_ON * 5);
    drive(1, 1, 32'hFFFFFFFF, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("rh_halted", 32'(halted), 1);
    chk("rh_pc", 32'(pc), 8);
    #1 rst_n = 0;
    #1;
    chk("rh_pc0", 32'(pc), 0);
    chk("rh_halt0", 32'(halted), 0);
    chk("rh_mis0", 32'(misalign_err), 0);
    chk("rh_cnt0", 32'(redirect_cnt), 0);
    chk("rh_flush0", 32'({flush_if_id, flush_id_ex}), 0);
    @(posedge clk); #1;
    rst_n = 1; ex_valid = 0; pc_sel = 0;
    #1;
    chk("rh_rel", 32'(pc), 0);
    drive(0, 0, 0, 0, 0);
    chk("rh_pc4", 32'(pc), 4);
    drive(0, 0, 0, 0, 0);
    chk("rh_pc8", 32'(pc), 8);
    @(posedge clk); #1;
    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
